// File: rtl/bfloat_add_param_if.sv
// Handshake bundle for the bfloat adder: operand channel in, result channel out.
// The producer side uses the master modport, the adder the slave modport.
interface bfloat_add_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, flags
  );
endinterface

// File: rtl/bfloat_add_param.sv
// Multi-cycle parameterised float adder/subtractor with round-to-nearest-even and
// flush-to-zero: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE, fixed latency.
module bfloat_add_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bfloat_add_param_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;             // {hidden, frac, G, R, S}
  localparam int XW = EXP_W + 2;             // signed working exponent
  localparam logic [EXP_W-1:0]    EMAX     = '1;
  localparam logic [EXP_W-1:0]    SH_MAX   = EXP_W'(MAN_W + 3);
  localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_e;

  state_e                 state_q;
  logic [W-1:0]           a_q, b_q, res_q, spec_res_q;
  logic                   op_q, sign_q, sub_q, zero_q, spec_q, spec_nv_q;
  logic                   in_ready_q, out_valid_q;
  logic [3:0]             flags_q;
  logic signed [XW-1:0]   exp_q;
  logic [SW-1:0]          big_q, small_q, norm_q;
  logic [SW:0]            add_q;

  // Align-stage decode and shift
  logic                   sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_big, lost;
  logic [EXP_W-1:0]       ea, eb, e_big, e_small, diff, sh;
  logic [MAN_W-1:0]       fa, fb, f_big, f_small;
  logic [SW-1:0]          ext_small, small_d, big_d;
  logic [W-1:0]           spec_res_d;
  logic                   spec_d, spec_nv_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sa = a_q[W-1];
    sb = b_q[W-1] ^ op_q;
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    nan_a  = (&ea) && (|fa);
    nan_b  = (&eb) && (|fb);
    inf_a  = (&ea) && !(|fa);
    inf_b  = (&eb) && !(|fb);
    zero_a = !(|ea);
    zero_b = !(|eb);

    spec_d     = 1'b1;
    spec_nv_d  = 1'b0;
    spec_res_d = QNAN;
    if (nan_a || nan_b) begin
      spec_res_d = QNAN;
    end else if (inf_a && inf_b && (sa != sb)) begin
      spec_nv_d = 1'b1;
    end else if (inf_a) begin
      spec_res_d = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      spec_res_d = {sb, EMAX, {MAN_W{1'b0}}};
    end else if (zero_a && zero_b) begin
      spec_res_d = {sa & sb, {(W-1){1'b0}}};
    end else if (zero_a) begin
      spec_res_d = {sb, eb, fb};
    end else if (zero_b) begin
      spec_res_d = a_q;
    end else begin
      spec_d = 1'b0;
    end

    a_big     = {ea, fa} >= {eb, fb};
    e_big     = a_big ? ea : eb;
    e_small   = a_big ? eb : ea;
    f_big     = a_big ? fa : fb;
    f_small   = a_big ? fb : fa;
    diff      = e_big - e_small;
    sh        = (diff > SH_MAX) ? SH_MAX : diff;
    ext_small = {1'b1, f_small, 3'b000};
    lost      = |(ext_small & ~({SW{1'b1}} << sh));
    small_d   = (ext_small >> sh) | {{(SW-1){1'b0}}, lost};
    big_d     = {1'b1, f_big, 3'b000};
  end

  // Normalise: carry-out shifts right, otherwise shift the leading one up to the hidden bit
  logic [SW-1:0]        norm_d;
  logic signed [XW-1:0] nexp_d;
  int                   lz;

  always_comb begin
    lz = 0;
    for (int i = 0; i < SW; i++) begin
      if (add_q[i]) lz = SW - 1 - i;
    end
    if (add_q[SW]) begin
      norm_d = {add_q[SW:2], add_q[1] | add_q[0]};
      nexp_d = exp_q + XW'(1);
    end else begin
      norm_d = add_q[SW-1:0] << lz;
      nexp_d = exp_q - XW'(lz);
    end
  end

  // Round to nearest even, then classify overflow / underflow on the final exponent
  logic                 g, r, s, up, carry;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         res_d;
  logic [3:0]           flags_d;

  always_comb begin
    g      = norm_q[2];
    r      = norm_q[1];
    s      = norm_q[0];
    up     = g & (r | s | norm_q[3]);
    mant_r = {1'b0, norm_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    carry  = mant_r[MAN_W+1];
    frac_r = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    exp_r  = exp_q + $signed({{(XW-1){1'b0}}, carry});
    if (spec_q) begin
      res_d   = spec_res_q;
      flags_d = {spec_nv_q, 3'b000};
    end else if (zero_q) begin
      res_d   = '0;
      flags_d = 4'b0000;
    end else if (exp_r >= EXP_TOP) begin
      res_d   = {sign_q, EMAX, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp_r <= 0) begin
      res_d   = {sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      res_d   = {sign_q, exp_r[EXP_W-1:0], frac_r};
      flags_d = {3'b000, g | r | s};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every register, datapath included, is reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      zero_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_nv_q   <= 1'b0;
      spec_res_q  <= '0;
      exp_q       <= '0;
      big_q       <= '0;
      small_q     <= '0;
      add_q       <= '0;
      norm_q      <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          a_q        <= bus.a;
          b_q        <= bus.b;
          op_q       <= bus.op;
          in_ready_q <= 1'b0;
          state_q    <= S_ALIGN;
        end
        S_ALIGN: begin
          spec_q     <= spec_d;
          spec_nv_q  <= spec_nv_d;
          spec_res_q <= spec_res_d;
          sign_q     <= a_big ? sa : sb;
          sub_q      <= sa ^ sb;
          exp_q      <= $signed({2'b00, e_big});
          big_q      <= big_d;
          small_q    <= small_d;
          state_q    <= S_ADD;
        end
        S_ADD: begin
          add_q   <= sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                           : ({1'b0, big_q} + {1'b0, small_q});
          state_q <= S_NORM;
        end
        S_NORM: begin
          norm_q  <= norm_d;
          exp_q   <= nexp_d;
          zero_q  <= (add_q == '0);
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          res_q       <= res_d;
          flags_q     <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (bus.out_ready) begin
          res_q       <= '0;
          flags_q     <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = res_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_bfloat_add_param.sv
// Self-checking bench: bfloat16 and 5/10 instances against an exact-arithmetic
// reference (wide integers, RNE, flush-to-zero), plus directed handshake/reset steps.
module tb_bfloat_add_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;           // 0: EXP_W=8/MAN_W=7, 1: EXP_W=5/MAN_W=10
  logic        drv_valid = 1'b0, drv_ready = 1'b0, drv_op = 1'b0;
  logic [15:0] drv_a = '0, drv_b = '0;
  int          n_pass = 0, n_total = 0, n_fail = 0;

  bfloat_add_param_if #(.EXP_W(8), .MAN_W(7))  bus8 ();
  bfloat_add_param_if #(.EXP_W(5), .MAN_W(10)) bus5 ();

  assign bus8.in_valid  = drv_valid && (sel == 0);
  assign bus8.out_ready = drv_ready && (sel == 0);
  assign bus8.a = drv_a;
  assign bus8.b = drv_b;
  assign bus8.op = drv_op;
  assign bus5.in_valid  = drv_valid && (sel == 1);
  assign bus5.out_ready = drv_ready && (sel == 1);
  assign bus5.a = drv_a;
  assign bus5.b = drv_b;
  assign bus5.op = drv_op;

  bfloat_add_param #(.EXP_W(8), .MAN_W(7))  dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));
  bfloat_add_param #(.EXP_W(5), .MAN_W(10)) dut5 (.clk_i(clk), .rst_i(rst), .bus(bus5));

  logic        obs_in_ready, obs_out_valid;
  logic [15:0] obs_sum;
  logic [3:0]  obs_flags;
  assign obs_in_ready  = (sel == 0) ? bus8.in_ready  : bus5.in_ready;
  assign obs_out_valid = (sel == 0) ? bus8.out_valid : bus5.out_valid;
  assign obs_sum       = (sel == 0) ? bus8.sum       : bus5.sum;
  assign obs_flags     = (sel == 0) ? bus8.flags     : bus5.flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact reference: operands become integers in units of the smallest normal ulp.
  function automatic void ref_add(input int ew, input int mw, input logic [15:0] a,
                                  input logic [15:0] b, input logic op,
                                  output logic [15:0] res, output logic [3:0] fl);
    int emax, ea, eb, p, sh, e;
    logic sa, sb, sr;
    logic [31:0] fa, fb, mant, qn;
    logic [299:0] ma, mb, mag, rem, half, one;
    emax = (1 << ew) - 1;
    sa = a[ew+mw];
    sb = b[ew+mw] ^ op;
    ea = int'(a >> mw) & emax;
    eb = int'(b >> mw) & emax;
    fa = 32'(a) & ((32'd1 << mw) - 1);
    fb = 32'(b) & ((32'd1 << mw) - 1);
    qn = (32'(emax) << mw) | (32'd1 << (mw - 1));
    res = '0;
    fl = '0;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0)) begin
      res = 16'(qn);
    end else if (ea == emax && eb == emax && sa != sb) begin
      res = 16'(qn);
      fl = 4'b1000;
    end else if (ea == emax || eb == emax) begin
      res = 16'(32'(emax) << mw);
      res[ew+mw] = (ea == emax) ? sa : sb;
    end else if (ea == 0 && eb == 0) begin
      res[ew+mw] = sa & sb;
    end else if (ea == 0) begin
      res = b;
      res[ew+mw] = sb;
    end else if (eb == 0) begin
      res = a;
    end else begin
      one = 1;
      ma = 300'((32'd1 << mw) | fa) << (ea - 1);
      mb = 300'((32'd1 << mw) | fb) << (eb - 1);
      if (sa == sb)      begin mag = ma + mb; sr = sa; end
      else if (ma >= mb) begin mag = ma - mb; sr = sa; end
      else               begin mag = mb - ma; sr = sb; end
      if (mag != 0) begin
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - mw + 1;
        sh = p - mw;
        rem = '0;
        if (sh > 0) begin
          mant = 32'(mag >> sh);
          rem  = mag & ((one << sh) - one);
          half = one << (sh - 1);
          if (rem > half || (rem == half && mant[0])) mant++;
        end else begin
          mant = 32'(mag << (-sh));
        end
        if (mant == (32'd1 << (mw + 1))) begin
          mant = mant >> 1;
          e++;
        end
        if (e >= emax) begin
          res = 16'(32'(emax) << mw);
          fl = 4'b0101;
        end else if (e <= 0) begin
          fl = 4'b0011;
        end else begin
          res = 16'((32'(e) << mw) | (mant & ((32'd1 << mw) - 1)));
          fl = {3'b000, rem != 0};
        end
        res[ew+mw] = sr;
      end
    end
  endfunction

  task automatic gen_pair(input int ew, input int mw, output logic [15:0] a, output logic [15:0] b);
    int emax, ea, eb, k, d;
    logic [31:0] fa, fb;
    emax = (1 << ew) - 1;
    k  = $urandom_range(0, 9);
    ea = (k == 0) ? 0 : (k == 1) ? emax : int'($urandom_range(1, emax - 1));
    fa = $urandom & ((32'd1 << mw) - 1);
    fb = $urandom & ((32'd1 << mw) - 1);
    k  = $urandom_range(0, 9);
    if (k == 0) eb = 0;
    else if (k == 1) eb = emax;
    else if (k < 6) begin
      d  = $urandom_range(0, 4);
      eb = ea + d - 2;
      if (eb < 1) eb = 1;
      if (eb > emax - 1) eb = emax - 1;
      if (k == 2) fb = fa;
    end else eb = $urandom_range(1, emax - 1);
    if (ea == emax && $urandom_range(0, 1) == 1) fa = 0;
    if (eb == emax && $urandom_range(0, 1) == 1) fb = 0;
    a = 16'((32'($urandom_range(0, 1)) << (ew + mw)) | (32'(ea) << mw) | fa);
    b = 16'((32'($urandom_range(0, 1)) << (ew + mw)) | (32'(eb) << mw) | fb);
  endtask

  // One transaction: accept, count edges to out_valid, compare, optionally stall, release.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op, input int hold,
                        output logic [15:0] got_sum, output logic [3:0] got_fl);
    int n;
    logic [15:0] exp_sum;
    logic [3:0]  exp_fl;
    ref_add((sel == 0) ? 8 : 5, (sel == 0) ? 7 : 10, a, b, op, exp_sum, exp_fl);
    n = 0;
    while (!obs_in_ready && n < 10) begin @(posedge clk); #1; n++; end
    check("in_ready_wait", obs_in_ready, 1);
    drv_a = a; drv_b = b; drv_op = op; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_a = 16'($urandom); drv_b = 16'($urandom); drv_op = 1'($urandom);
    n = 0;
    while (!obs_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", n, 4);
    got_sum = obs_sum;
    got_fl  = obs_flags;
    check($sformatf("sum %h%s%h", a, op ? "-" : "+", b), got_sum, exp_sum);
    check($sformatf("flags %h%s%h", a, op ? "-" : "+", b), got_fl, exp_fl);
    for (int h = 0; h < hold; h++) begin
      drv_valid = 1'b1;
      drv_a = 16'($urandom); drv_b = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", obs_out_valid, 1);
      check("hold_sum", obs_sum, got_sum);
      check("hold_flags", obs_flags, got_fl);
      check("hold_in_ready", obs_in_ready, 0);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    check("release_out_valid", obs_out_valid, 0);
    check("release_in_ready", obs_in_ready, 1);
  endtask

  initial begin
    logic [15:0] s, ra, rb;
    logic [3:0]  f;
    int n;

    // Reset state, both configurations
    #3;
    for (int c = 0; c < 2; c++) begin
      sel = c; #1;
      check("rst_out_valid", obs_out_valid, 0);
      check("rst_sum", obs_sum, 0);
      check("rst_flags", obs_flags, 0);
    end
    sel = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", obs_in_ready, 1);

    // Directed bfloat16 cases
    run_op(16'h3F80, 16'h3F80, 1'b0, 0, s, f);
    check("one_plus_one", s, 16'h4000);
    check("one_plus_one_fl", f, 4'h0);
    run_op(16'h3F80, 16'h3F80, 1'b1, 0, s, f);
    check("one_minus_one", s, 16'h0000);
    run_op(16'h8000, 16'h0000, 1'b1, 0, s, f);
    check("negzero", s, 16'h8000);
    run_op(16'h7F80, 16'hFF80, 1'b0, 0, s, f);
    check("inf_minus_inf", s, 16'h7FC0);
    check("inf_minus_inf_nv", f, 4'b1000);
    run_op(16'h7FC1, 16'h3F80, 1'b0, 0, s, f);
    check("nan_in", s, 16'h7FC0);
    check("nan_in_fl", f, 4'b0000);
    run_op(16'h7F7F, 16'h7F7F, 1'b0, 0, s, f);
    check("overflow", s, 16'h7F80);
    check("overflow_fl", f, 4'b0101);
    run_op(16'h3F80, 16'h3B80, 1'b0, 0, s, f);
    check("tie_even", s, 16'h3F80);
    check("tie_even_fl", f, 4'b0001);
    run_op(16'h0081, 16'h0080, 1'b1, 0, s, f);
    check("underflow_fl", f, 4'b0011);

    // Stall the consumer for three cycles
    run_op(16'h4040, 16'h3F80, 1'b0, 3, s, f);
    check("stall_sum", s, 16'h4080);

    // Reset while in ADD: no result must appear for the discarded operation
    drv_a = 16'h4000; drv_b = 16'h4000; drv_op = 1'b0; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("mid_rst_out_valid", obs_out_valid, 0);
    check("mid_rst_sum", obs_sum, 0);
    check("mid_rst_flags", obs_flags, 0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (obs_out_valid) n++;
    end
    check("no_stale_valid", n, 0);
    run_op(16'h3F80, 16'h3F80, 1'b0, 0, s, f);
    check("after_rst", s, 16'h4000);

    // Reset while a result is being held clears the outputs asynchronously
    drv_a = 16'h3F80; drv_b = 16'h4000; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("held_valid", obs_out_valid, 1);
    #2 rst = 1'b1; #1;
    check("async_rst_valid", obs_out_valid, 0);
    check("async_rst_sum", obs_sum, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Half-precision-shaped configuration
    sel = 1; #1;
    run_op(16'h3C00, 16'h3C00, 1'b0, 0, s, f);
    check("h_one_plus_one", s, 16'h4000);
    run_op(16'h7BFF, 16'h7BFF, 1'b0, 0, s, f);
    check("h_overflow", s, 16'h7C00);
    check("h_overflow_fl", f, 4'b0101);
    run_op(16'h3C00, 16'h1000, 1'b1, 1, s, f);

    // Randomised operands against the reference, both configurations
    for (int c = 0; c < 2; c++) begin
      sel = c; #1;
      for (int i = 0; i < 150; i++) begin
        gen_pair((c == 0) ? 8 : 5, (c == 0) ? 7 : 10, ra, rb);
        run_op(ra, rb, 1'($urandom), (i % 17 == 0) ? 1 : 0, s, f);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bfloat_add_param.md
BFLOAT_ADD_PARAM -- requirements
Module: bfloat_add_param

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 7, stored fraction width; W = 1+EXP_W+MAN_W (default 16 = bfloat16).
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  W  operand A, {sign, exp, frac}.
REQ-008 b  in  W  operand B, same format.
REQ-009 op  in  1  0 = A+B, 1 = A-B; sampled with operands.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 sum  out  W  rounded result.
REQ-013 flags  out  4  {nv, of, uf, nx}: invalid, overflow, underflow, inexact.

Function
REQ-014 SHALL implement FSM IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE; one state per cycle except IDLE and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a, b, op captured on the edge where in_valid && in_ready; later input changes ignored.
REQ-016 out_valid SHALL rise exactly 4 edges after the accepting edge and stay high with sum/flags stable until an edge with out_ready=1, then return to IDLE; in_ready high the following cycle (no same-cycle accept).
REQ-017 Latency SHALL be fixed for all operands, including special cases resolved in ALIGN.
REQ-018 Effective B sign = b.sign XOR op.
REQ-019 Exponent-zero inputs (zero/subnormal) SHALL be treated as signed zero (flush-to-zero).
REQ-020 ALIGN: larger-magnitude operand selected by {exp,frac} compare; smaller significand (hidden 1 prepended) right-shifted by the exponent difference into guard, round, and sticky bits; sticky ORs every bit shifted out; shift saturates at MAN_W+3.
REQ-021 ADD: equal effective signs add, otherwise subtract smaller from larger; result sign = larger operand sign.
REQ-022 NORM: carry-out -> shift right 1, exp+1 (shifted bit ORed into sticky); else left-shift to leading 1 with exp decremented by the same amount, any shift count up to MAN_W+1.
REQ-023 ROUND: round-to-nearest-even on G/R/sticky; nx=1 if any of G/R/sticky set; mantissa carry from rounding SHALL increment exponent.
REQ-024 Result exponent >= 2^EXP_W-1 SHALL give signed infinity, of=1, nx=1.
REQ-025 Result exponent <= 0 SHALL give signed zero, uf=1, nx=1.
REQ-026 Exact zero from cancellation SHALL be +0; -0 only when both effective operands are -0.
REQ-027 Any NaN input SHALL give canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0), nv=0.
REQ-028 +inf plus -inf (effective) SHALL give canonical qNaN, nv=1; inf plus finite/same-sign inf gives that inf, flags 0.
REQ-029 Flags not set by a rule SHALL be 0; flags valid only while out_valid=1.

Reset
REQ-030 While reset=1: state IDLE, in_ready=1 once released, out_valid=0, sum=0, flags=0, internal registers 0.
REQ-031 Reset mid-operation SHALL discard the in-flight operation; no out_valid produced for it.

Verification
REQ-032 a=3F80, b=3F80, op=0 -> sum=4000, flags=0, out_valid exactly 4 edges after accept.
REQ-033 a=3F80, b=3F80, op=1 -> sum=0000, flags=0; a=8000, b=0000, op=1 -> sum=8000.
REQ-034 a=7F80, b=FF80, op=0 -> sum=7FC0, nv=1; a=7FC1, b=3F80 -> 7FC0, nv=0.
REQ-035 a=7F7F, b=7F7F -> sum=7F80, of=1, nx=1; a=3F80, b=3B80 -> sum=3F80, nx=1 (tie to even).
REQ-036 Hold out_ready=0 for 3 cycles after out_valid: sum/flags stable, in_ready=0; new in_valid ignored until IDLE.
REQ-037 Assert reset in ADD state -> outputs zero asynchronously, no stale out_valid; next accepted pair computes correctly.
REQ-038 Rerun REQ-032/REQ-035 with EXP_W=5, MAN_W=10: 3C00+3C00 -> 4000; 7BFF+7BFF -> 7C00, of=1.
